// File: rtl/matmul_apb_sequencer.sv
// APB master that drives one matmul job through the slave's register map:
// program job fields, set START, poll DONE with a gap and timeout, clear START, respond.
module matmul_apb_sequencer #(
    parameter int AWIDTH    = 16,
    parameter int DWIDTH    = 5,
    parameter int POLL_GAP  = 4,
    parameter int MAX_POLLS = 255
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic              job_fp,
    input  logic [DWIDTH-1:0] job_addr_a,
    input  logic [DWIDTH-1:0] job_addr_b,
    input  logic [DWIDTH-1:0] job_addr_c,
    input  logic [DWIDTH-1:0] job_str_a,
    input  logic [DWIDTH-1:0] job_str_b,
    input  logic [DWIDTH-1:0] job_str_c,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [AWIDTH-1:0] PADDR,
    output logic [DWIDTH-1:0] PWDATA,
    input  logic [DWIDTH-1:0] PRDATA,
    input  logic              PREADY,
    output logic              busy,
    output logic              resp_valid,
    output logic              resp_exception,
    output logic              resp_timeout
);

    localparam int GW = $clog2(POLL_GAP + 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic              fp;
        logic [DWIDTH-1:0] a;
        logic [DWIDTH-1:0] b;
        logic [DWIDTH-1:0] c;
        logic [DWIDTH-1:0] sa;
        logic [DWIDTH-1:0] sb;
        logic [DWIDTH-1:0] sc;
    } job_t;

    state_t            state_q, state_d;
    logic [3:0]        step_q, step_d;
    logic [7:0]        poll_q, poll_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              exc_q, exc_d;
    logic              tmo_q, tmo_d;
    job_t              job_q, job_d;

    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [AWIDTH-1:0] paddr_q, paddr_d;
    logic [DWIDTH-1:0] pwdata_q, pwdata_d;
    logic              busy_q, busy_d;
    logic              rvalid_q, rvalid_d;
    logic              rexc_q, rexc_d;
    logic              rtmo_q, rtmo_d;
    logic              ready_q, ready_d;

    logic [AWIDTH-1:0] step_addr;
    logic [DWIDTH-1:0] step_data;

    // Only done (bit 1) and exception (bit 2) carry meaning on the status read.
    logic unused_prdata;
    assign unused_prdata = ^{PRDATA[DWIDTH-1:3], PRDATA[0]};

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        poll_d  = poll_q;
        gap_d   = gap_q;
        exc_d   = exc_q;
        tmo_d   = tmo_q;
        job_d   = job_q;
        case (state_q)
            S_IDLE: begin
                if (job_valid) begin
                    job_d   = '{fp: job_fp, a: job_addr_a, b: job_addr_b, c: job_addr_c,
                                sa: job_str_a, sb: job_str_b, sc: job_str_c};
                    step_d  = '0;
                    poll_d  = '0;
                    exc_d   = 1'b0;
                    tmo_d   = 1'b0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: begin
                if (PREADY) begin
                    if (step_q < 4'd8) begin
                        step_d  = step_q + 4'd1;
                        state_d = S_SETUP;
                    end else if (step_q == 4'd8) begin
                        if (PRDATA[1]) begin
                            exc_d   = PRDATA[2];
                            step_d  = 4'd9;
                            state_d = S_SETUP;
                        end else if ((32'(poll_q) + 32'd1) < 32'(MAX_POLLS)) begin
                            poll_d  = poll_q + 8'd1;
                            gap_d   = GW'(POLL_GAP);
                            state_d = S_WAIT;
                        end else begin
                            tmo_d   = 1'b1;
                            step_d  = 4'd9;
                            state_d = S_SETUP;
                        end
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (gap_q <= GW'(1)) state_d = S_SETUP;
                else                 gap_d   = gap_q - GW'(1);
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the APB pins come straight from flops.
    always_comb begin
        step_addr = '0;
        step_data = '0;
        case (step_d)
            4'd0: begin step_addr = AWIDTH'(3); step_data = DWIDTH'(job_d.fp); end
            4'd1: begin step_addr = AWIDTH'(4); step_data = job_d.a;  end
            4'd2: begin step_addr = AWIDTH'(5); step_data = job_d.b;  end
            4'd3: begin step_addr = AWIDTH'(6); step_data = job_d.c;  end
            4'd4: begin step_addr = AWIDTH'(7); step_data = job_d.sa; end
            4'd5: begin step_addr = AWIDTH'(8); step_data = job_d.sb; end
            4'd6: begin step_addr = AWIDTH'(9); step_data = job_d.sc; end
            4'd7: begin step_addr = AWIDTH'(1); step_data = DWIDTH'(1); end
            4'd8: step_addr = AWIDTH'(2);
            4'd9: step_addr = AWIDTH'(1);
            default: ;
        endcase
        psel_d    = (state_d == S_SETUP) || (state_d == S_ACCESS);
        penable_d = (state_d == S_ACCESS);
        pwrite_d  = psel_d && (step_d != 4'd8);
        paddr_d   = psel_d ? step_addr : '0;
        pwdata_d  = pwrite_d ? step_data : '0;
        busy_d    = psel_d || (state_d == S_WAIT);
        rvalid_d  = (state_d == S_RESP);
        rexc_d    = rvalid_d && exc_d;
        rtmo_d    = rvalid_d && tmo_d;
        ready_d   = (state_d == S_IDLE);
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            poll_q    <= '0;
            gap_q     <= '0;
            exc_q     <= 1'b0;
            tmo_q     <= 1'b0;
            job_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            busy_q    <= 1'b0;
            rvalid_q  <= 1'b0;
            rexc_q    <= 1'b0;
            rtmo_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            poll_q    <= poll_d;
            gap_q     <= gap_d;
            exc_q     <= exc_d;
            tmo_q     <= tmo_d;
            job_q     <= job_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            busy_q    <= busy_d;
            rvalid_q  <= rvalid_d;
            rexc_q    <= rexc_d;
            rtmo_q    <= rtmo_d;
            ready_q   <= ready_d;
        end
    end

    assign job_ready      = ready_q;
    assign PSEL           = psel_q;
    assign PENABLE        = penable_q;
    assign PWRITE         = pwrite_q;
    assign PADDR          = paddr_q;
    assign PWDATA         = pwdata_q;
    assign busy           = busy_q;
    assign resp_valid     = rvalid_q;
    assign resp_exception = rexc_q;
    assign resp_timeout   = rtmo_q;

endmodule

// File: tb/tb_matmul_apb_sequencer.sv
// Directed bench: APB slave model with configurable wait states and DONE behaviour,
// a transfer-list/latency model of each job, and a per-cycle compare process.
module tb_matmul_apb_sequencer;

    localparam int AW   = 16;
    localparam int DW   = 5;
    localparam int GAP  = 4;
    localparam int MAXP = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          job_valid = 1'b0;
    logic          job_ready;
    logic          j_fp = 1'b0;
    logic [DW-1:0] j_a = '0, j_b = '0, j_c = '0, j_sa = '0, j_sb = '0, j_sc = '0;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;
    logic          busy, resp_valid, resp_exc, resp_tmo;

    always #5 clk = ~clk;

    matmul_apb_sequencer #(.AWIDTH(AW), .DWIDTH(DW), .POLL_GAP(GAP), .MAX_POLLS(MAXP)) dut (
        .PCLK(clk), .PRESET(rst),
        .job_valid(job_valid), .job_ready(job_ready), .job_fp(j_fp),
        .job_addr_a(j_a), .job_addr_b(j_b), .job_addr_c(j_c),
        .job_str_a(j_sa), .job_str_b(j_sb), .job_str_c(j_sc),
        .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prdata), .PREADY(pready),
        .busy(busy), .resp_valid(resp_valid), .resp_exception(resp_exc), .resp_timeout(resp_tmo)
    );

    typedef struct packed {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } xfer_t;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // slave configuration, set by the stimulus before each job
    int cfg_waits = 0;
    int cfg_done_after = 1;   // 0 = DONE never asserts
    bit cfg_exc = 1'b0;

    // model state
    xfer_t expq[$];
    xfer_t xlog[$];
    int    cyc = 0;
    bit    in_job = 1'b0;
    int    acc_cyc = 0, exp_resp_cyc = -1, resp_cyc = 0;
    int    acc_count = 0, resp_count = 0;
    bit    exp_exc, exp_tmo, got_exc, got_tmo;
    int    acc_wait = 0, rd_n = 0;
    logic          p_psel = 0, p_pen = 0, p_pwrite = 0, p_pready = 0;
    logic [AW-1:0] p_paddr = '0;
    logic [DW-1:0] p_pwdata = '0;

    function automatic xfer_t mk(input logic w, input int a, input logic [DW-1:0] d);
        xfer_t x;
        x.w = w; x.a = AW'(a); x.d = d;
        return x;
    endfunction

    task automatic build_model();
        int nreads;
        expq.delete();
        expq.push_back(mk(1, 3, DW'(j_fp)));
        expq.push_back(mk(1, 4, j_a));
        expq.push_back(mk(1, 5, j_b));
        expq.push_back(mk(1, 6, j_c));
        expq.push_back(mk(1, 7, j_sa));
        expq.push_back(mk(1, 8, j_sb));
        expq.push_back(mk(1, 9, j_sc));
        expq.push_back(mk(1, 1, DW'(1)));
        exp_tmo = (cfg_done_after == 0) || (cfg_done_after > MAXP);
        nreads  = exp_tmo ? MAXP : cfg_done_after;
        exp_exc = !exp_tmo && cfg_exc;
        for (int i = 0; i < nreads; i++) expq.push_back(mk(0, 2, '0));
        expq.push_back(mk(1, 1, '0));
        exp_resp_cyc = acc_cyc + (9 + nreads) * (2 + cfg_waits) + (nreads - 1) * GAP;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            in_job = 0; expq.delete(); pready = 0; prdata = '0; acc_wait = 0;
            exp_resp_cyc = -1; p_psel = 0; p_pen = 0; p_pready = 0;
        end else begin
            // slave response for this cycle
            if (psel && penable) begin
                pready = (acc_wait == cfg_waits);
                acc_wait++;
            end else begin
                pready = 0;
                acc_wait = 0;
            end
            prdata = '0;
            if (psel && penable && pready && !pwrite) begin
                rd_n++;
                if (cfg_done_after != 0 && rd_n == cfg_done_after)
                    prdata = cfg_exc ? 5'b00110 : 5'b00010;
            end

            check("penable_without_psel", 32'(penable && !psel), 0);
            if (p_psel && !(p_pen && p_pready)) begin
                check("phase_psel", 32'(psel), 1);
                check("phase_penable", 32'(penable), 1);
                check("phase_paddr", 32'(paddr), 32'(p_paddr));
                check("phase_pwrite", 32'(pwrite), 32'(p_pwrite));
                check("phase_pwdata", 32'(pwdata), 32'(p_pwdata));
            end

            if (psel && penable && pready) begin
                xlog.push_back(mk(pwrite, int'(paddr), pwdata));
                if (expq.size() == 0) begin
                    check("extra_transfer", 32'(paddr), 32'hFFFF_FFFF);
                end else begin
                    xfer_t e;
                    e = expq.pop_front();
                    check("xfer_write", 32'(pwrite), 32'(e.w));
                    check("xfer_addr", 32'(paddr), 32'(e.a));
                    check("xfer_data", 32'(pwdata), 32'(e.d));
                end
            end

            if (in_job) begin
                bit r;
                r = (cyc == exp_resp_cyc);
                check("resp_valid", 32'(resp_valid), 32'(r));
                check("busy", 32'(busy), 32'(!r));
                check("job_ready_busy", 32'(job_ready), 0);
                if (r) begin
                    check("resp_exception", 32'(resp_exc), 32'(exp_exc));
                    check("resp_timeout", 32'(resp_tmo), 32'(exp_tmo));
                    check("xfers_left", expq.size(), 0);
                    got_exc = resp_exc; got_tmo = resp_tmo;
                    in_job = 0; resp_cyc = cyc; resp_count++;
                end
            end else begin
                check("idle_busy", 32'(busy), 0);
                check("idle_resp", 32'(resp_valid), 0);
                check("idle_psel", 32'(psel), 0);
                check("idle_job_ready", 32'(job_ready), 1);
                if (job_valid && job_ready) begin
                    acc_cyc = cyc + 1;
                    rd_n = 0;
                    build_model();
                    in_job = 1;
                    acc_count++;
                end
            end
            p_psel = psel; p_pen = penable; p_pwrite = pwrite;
            p_paddr = paddr; p_pwdata = pwdata; p_pready = pready;
        end
    end

    task automatic wait_accept(input int target);
        int n = 0;
        while (acc_count < target && n < 50) begin
            @(posedge clk); #2; n++;
        end
        if (acc_count < target) check("accept_timeout", acc_count, target);
    endtask

    task automatic wait_resp(input int target);
        int n = 0;
        while (resp_count < target && n < 1000) begin
            @(posedge clk); #2; n++;
        end
        if (resp_count < target) check("resp_timeout_wait", resp_count, target);
    endtask

    task automatic run_job(input int lat_lit);
        int r0;
        r0 = resp_count;
        xlog.delete();
        @(posedge clk); #2;
        job_valid = 1;
        wait_accept(acc_count + 1);
        job_valid = 0;
        wait_resp(r0 + 1);
        check("latency", resp_cyc - acc_cyc, lat_lit);
    endtask

    task automatic set_job1();
        j_fp = 1; j_a = 5'd3; j_b = 5'd7; j_c = 5'd12; j_sa = 5'd1; j_sb = 5'd2; j_sc = 5'd4;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_psel", 32'(psel), 0);
        check("rst_penable", 32'(penable), 0);
        check("rst_pwrite", 32'(pwrite), 0);
        check("rst_paddr", 32'(paddr), 0);
        check("rst_pwdata", 32'(pwdata), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_resp", 32'({resp_valid, resp_exc, resp_tmo}), 0);
        check("rst_job_ready", 32'(job_ready), 1);
        #1 rst = 0;
        repeat (2) @(posedge clk);

        // T1: zero-wait slave, done on first poll
        set_job1(); cfg_waits = 0; cfg_done_after = 1; cfg_exc = 0;
        run_job(20);
        check("t1_nxfer", xlog.size(), 10);
        if (xlog.size() == 10) begin
            check("t1_x0", 32'(xlog[0]), 32'(mk(1, 3, 5'd1)));
            check("t1_x3", 32'(xlog[3]), 32'(mk(1, 6, 5'd12)));
            check("t1_x6", 32'(xlog[6]), 32'(mk(1, 9, 5'd4)));
            check("t1_x7", 32'(xlog[7]), 32'(mk(1, 1, 5'd1)));
            check("t1_x8", 32'(xlog[8]), 32'(mk(0, 2, 5'd0)));
            check("t1_x9", 32'(xlog[9]), 32'(mk(1, 1, 5'd0)));
        end
        check("t1_flags", 32'({got_exc, got_tmo}), 0);

        // T2: three wait states per access
        cfg_waits = 3;
        run_job(50);
        check("t2_nxfer", xlog.size(), 10);

        // T3: done on third poll
        cfg_waits = 0; cfg_done_after = 3;
        j_fp = 0; j_a = 5'd31; j_b = 5'd0; j_c = 5'd17; j_sa = 5'd9; j_sb = 5'd30; j_sc = 5'd1;
        run_job(32);
        check("t3_nxfer", xlog.size(), 12);
        check("t3_flags", 32'({got_exc, got_tmo}), 0);

        // T4: done never asserts -> timeout after MAX_POLLS reads
        cfg_done_after = 0;
        run_job(44);
        check("t4_nxfer", xlog.size(), 14);
        check("t4_flags", 32'({got_exc, got_tmo}), 32'b01);

        // T5: exception with done; job_valid held across two jobs
        set_job1(); cfg_done_after = 1; cfg_exc = 1;
        begin
            int a0, r0, first_resp;
            a0 = acc_count; r0 = resp_count;
            @(posedge clk); #2;
            job_valid = 1;
            wait_accept(a0 + 1);
            wait_resp(r0 + 1);
            first_resp = resp_cyc;
            check("t5_flags", 32'({got_exc, got_tmo}), 32'b10);
            wait_accept(a0 + 2);
            job_valid = 0;
            check("t5_reaccept_gap", acc_cyc - first_resp, 2);
            wait_resp(r0 + 2);
            check("t5_second_flags", 32'({got_exc, got_tmo}), 32'b10);
        end

        // T6: reset during step 4 access
        cfg_exc = 0;
        begin
            int n = 0;
            @(posedge clk); #2;
            job_valid = 1;
            wait_accept(acc_count + 1);
            job_valid = 0;
            while (!(psel && penable && paddr == AW'(7)) && n < 100) begin
                @(posedge clk); #2; n++;
            end
            check("t6_reach_step4", 32'(psel && penable && paddr == AW'(7)), 1);
            rst = 1;
            #1;
            check("t6_async_psel", 32'(psel), 0);
            check("t6_async_penable", 32'(penable), 0);
            check("t6_async_busy", 32'(busy), 0);
            @(posedge clk); #2;
            rst = 0;
            @(negedge clk); #1;
            check("t6_busy", 32'(busy), 0);
            check("t6_job_ready", 32'(job_ready), 1);
        end
        set_job1();
        run_job(20);
        check("t6_restart_x0", (xlog.size() > 0) ? 32'(xlog[0]) : 32'hFFFF_FFFF, 32'(mk(1, 3, 5'd1)));

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
